// File: rtl/ahb_pkg.sv
// Shared AHB encodings, default sizing constants and the byte-lane helper
// used by the modport_slave block.
package ahb_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MEM_DEPTH  = 256;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1
  } hresp_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  // Little-endian byte-lane mask for a 32-bit word. Sizes above word fall
  // back to a full-word mask; misaligned low bits are ignored by the half
  // and word cases.
  function automatic logic [3:0] lane_mask(input logic [2:0] size,
                                           input logic [1:0] addr_lo);
    logic [3:0] mask;
    case (size)
      3'd0:    mask = 4'b0001 << addr_lo;
      3'd1:    mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/modport_slave_if.sv
// AHB-Lite bus bundle between a master (or testbench) and modport_slave.
// hready is driven by the master side / interconnect.
interface modport_slave_if
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [3:0]            hprot;
  logic                  hready;
  logic [DATA_WIDTH-1:0] hwdata;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hreadyout;
  logic [1:0]            hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hready, hwdata,
    input  hrdata, hreadyout, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hready, hwdata,
    output hrdata, hreadyout, hresp
  );

endinterface

// File: rtl/ahb_slave_mem.sv
// Byte-lane-enabled word memory: one synchronous write port with per-lane
// strobes and one combinational read port. Contents are never reset.
module ahb_slave_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(MEM_DEPTH)-1:0]  waddr,
  input  logic [DATA_WIDTH/8-1:0]       wstrb,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [$clog2(MEM_DEPTH)-1:0]  raddr,
  output logic [DATA_WIDTH-1:0]         rdata
);

  localparam int STRB_W = DATA_WIDTH / 8;

  // One independent byte-wide array per lane keeps each write single-driver.
  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
    logic [7:0] lane_mem [MEM_DEPTH];

    // Commit this lane when the write strobe for it is set.
    always_ff @(posedge clk) begin
      if (we && wstrb[gi]) begin
        lane_mem[waddr] <= wdata[gi*8 +: 8];
      end
    end

    assign rdata[gi*8 +: 8] = lane_mem[raddr];
  end

endmodule

// File: rtl/modport_slave.sv
// Zero-wait AHB-Lite memory slave. Address phase is registered, write data
// lands at the end of the data phase, reads are combinational from memory.
// Optional macro AHB_ERR_RESP_EN enables the two-cycle ERROR response for
// out-of-range, misaligned and oversized transfers; without it addresses
// wrap and the slave never errors.
module modport_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH
) (
  input  logic            hclk,
  input  logic            hresetn,  // active-high despite the name
  modport_slave_if.slave  bus
);

  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int STRB_W = DATA_WIDTH / 8;

`ifdef AHB_ERR_RESP_EN
  typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_e;
`else
  typedef enum logic {IDLE} state_e;
`endif

  state_e state_reg;
  state_e state_next;

  logic             accept;
  logic             addr_err;
  logic             dphase_valid_reg;
  logic             dphase_write_reg;
  logic [IDX_W-1:0] dphase_idx_reg;
  logic [1:0]       dphase_lo_reg;
  logic [2:0]       dphase_size_reg;
  logic [STRB_W-1:0] dphase_strb;
  logic             mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic             ready_out;
  logic [1:0]       resp_out;
  logic             unused_bits;

  // BUSY/IDLE carry no access; SEQ is handled exactly like NONSEQ.
  assign accept = bus.hsel && bus.hready && bus.htrans[1];

`ifdef AHB_ERR_RESP_EN
  assign addr_err = (bus.haddr >= ADDR_WIDTH'(MEM_DEPTH * 4))
                 || (bus.hsize > 3'd2)
                 || ((bus.hsize == HSIZE_HALF) && bus.haddr[0])
                 || ((bus.hsize == HSIZE_WORD) && (bus.haddr[1:0] != 2'b00));
`else
  assign addr_err = 1'b0;
`endif

  // Response FSM state register.
  always_ff @(posedge hclk or posedge hresetn) begin
    if (hresetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and response outputs; errored transfers never reach memory.
  always_comb begin
    state_next = state_reg;
    ready_out  = 1'b1;
    resp_out   = HRESP_OKAY;
    case (state_reg)
`ifdef AHB_ERR_RESP_EN
      IDLE: begin
        if (accept && addr_err) state_next = ERR1;
      end
      ERR1: begin
        ready_out  = 1'b0;
        resp_out   = HRESP_ERROR;
        state_next = ERR2;
      end
      ERR2: begin
        resp_out   = HRESP_ERROR;
        state_next = (accept && addr_err) ? ERR1 : IDLE;
      end
`else
      IDLE: state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  // Address-phase capture; holds while the bus is stalled.
  always_ff @(posedge hclk or posedge hresetn) begin
    if (hresetn) begin
      dphase_valid_reg <= 1'b0;
      dphase_write_reg <= 1'b0;
      dphase_idx_reg   <= '0;
      dphase_lo_reg    <= 2'b00;
      dphase_size_reg  <= 3'd0;
    end else if (bus.hready) begin
      dphase_valid_reg <= accept && !addr_err;
      dphase_write_reg <= bus.hwrite;
      dphase_idx_reg   <= bus.haddr[IDX_W+1:2];
      dphase_lo_reg    <= bus.haddr[1:0];
      dphase_size_reg  <= bus.hsize;
    end
  end

  assign dphase_strb = STRB_W'(lane_mask(dphase_size_reg, dphase_lo_reg));
  assign mem_we      = dphase_valid_reg && dphase_write_reg && bus.hready;

  ahb_slave_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_mem (
    .clk   (hclk),
    .we    (mem_we),
    .waddr (dphase_idx_reg),
    .wstrb (dphase_strb),
    .wdata (bus.hwdata),
    .raddr (dphase_idx_reg),
    .rdata (mem_rdata)
  );

  // A write committed at the edge that registers a following read address
  // is already visible here, so back-to-back read-after-write needs no bypass.
  assign bus.hrdata    = (dphase_valid_reg && !dphase_write_reg) ? mem_rdata : '0;
  assign bus.hreadyout = ready_out;
  assign bus.hresp     = resp_out;

  // Burst type and protection are informational only.
  assign unused_bits = ^{bus.hburst, bus.hprot, bus.haddr};

endmodule

// File: tb/tb_modport_slave.sv
// Scoreboard bench for modport_slave: stimulus pushes expected data-phase
// responses; a negedge monitor pops and compares whenever a data phase
// (or stalled continuation) is on the bus. Honours AHB_ERR_RESP_EN.
module tb_modport_slave;
  import ahb_pkg::*;

  logic hclk = 1'b0;
  logic hresetn = 1'b1;
  always #5 hclk = ~hclk;

  modport_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  assign bus.hready = bus.hreadyout;

  modport_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        rdy;
    logic [1:0]  resp;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          passes = 0;
  logic [31:0] wdata_pend = 32'h0;
  logic        pend = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
  endtask

  task automatic push(input string name, input logic [31:0] rd, input logic rdy, input logic [1:0] resp);
    exp_t e;
    e.name = name; e.rd = rd; e.rdy = rdy; e.resp = resp;
    exp_q.push_back(e);
  endtask

  // One bus cycle: present an address phase plus the previous beat's write data.
  task automatic beat(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wd, input string name, input logic [31:0] exp_rd);
    bus.hsel   = sel;
    bus.htrans = trans;
    bus.hwrite = wr;
    bus.haddr  = addr;
    bus.hsize  = size;
    bus.hburst = HBURST_INCR;
    bus.hprot  = 4'h3;
    bus.hwdata = wdata_pend;
    wdata_pend = wd;
    if (sel && trans[1]) push(name, wr ? 32'h0 : exp_rd, 1'b1, HRESP_OKAY);
    @(posedge hclk); #1;
  endtask

  task automatic idle();
    beat(1'b1, HTRANS_IDLE, 1'b0, 32'h0, 3'd2, 32'h0, "idle", 32'h0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wd, input string name);
    beat(1'b1, HTRANS_NONSEQ, 1'b1, addr, size, wd, name, 32'h0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp_rd, input string name);
    beat(1'b1, HTRANS_NONSEQ, 1'b0, addr, 3'd2, 32'h0, name, exp_rd);
  endtask

`ifdef AHB_ERR_RESP_EN
  // Erroring transfer: expect ERROR with wait, then ERROR with ready; the
  // two following cycles are kept idle.
  task automatic err_xfer(input logic w, input logic [31:0] addr, input logic [2:0] size, input string name);
    bus.hsel = 1'b1; bus.htrans = HTRANS_NONSEQ; bus.hwrite = w;
    bus.haddr = addr; bus.hsize = size; bus.hwdata = wdata_pend;
    wdata_pend = 32'hFFFF_FFFF;
    push({name, " err1"}, 32'h0, 1'b0, HRESP_ERROR);
    push({name, " err2"}, 32'h0, 1'b1, HRESP_ERROR);
    @(posedge hclk); #1;
    idle();
    idle();
  endtask
`endif

  // Monitor: compare each data-phase response against the scoreboard and
  // require the quiet OKAY response on every other cycle.
  always @(negedge hclk) begin
    if (pend) begin
      if (exp_q.size() == 0) begin
        check("unexpected data phase", 64'(exp_q.size()), 64'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, " hrdata"},    64'(bus.hrdata),    64'(e.rd));
        check({e.name, " hreadyout"}, 64'(bus.hreadyout), 64'(e.rdy));
        check({e.name, " hresp"},     64'(bus.hresp),     64'(e.resp));
      end
    end else begin
      check("quiet response", {29'b0, bus.hrdata, bus.hreadyout, bus.hresp},
            {29'b0, 32'h0, 1'b1, 2'b00});
    end
    pend = !hresetn && ((bus.hsel && bus.hready && bus.htrans[1]) || !bus.hreadyout);
  end

  initial begin
    bus.hsel = 1'b0; bus.haddr = 32'h0; bus.htrans = HTRANS_IDLE; bus.hwrite = 1'b0;
    bus.hsize = 3'd2; bus.hburst = 3'd0; bus.hprot = 4'h0; bus.hwdata = 32'h0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    check("reset hreadyout", 64'(bus.hreadyout), 64'd1);
    check("reset hresp",     64'(bus.hresp),     64'd0);
    check("reset hrdata",    64'(bus.hrdata),    64'd0);
    @(posedge hclk); #1;
    hresetn = 1'b0;

    // Word write then immediate read of the same address.
    wr(32'h10, 3'd2, 32'hDEAD_BEEF, "wr word 0x10");
    rd(32'h10, 32'hDEAD_BEEF, "raw rd 0x10");

    // Byte lane 1 over a zeroed word.
    wr(32'h10, 3'd2, 32'h0000_0000, "clear 0x10");
    wr(32'h11, 3'd0, 32'h5555_AA55, "wr byte 0x11");
    rd(32'h10, 32'h0000_AA00, "rd byte lane");

    // Halfword and high byte lanes.
    wr(32'h14, 3'd2, 32'h1122_3344, "wr word 0x14");
    wr(32'h16, 3'd1, 32'hBEEF_9999, "wr half 0x16");
    wr(32'h14, 3'd1, 32'h7777_CAFE, "wr half 0x14");
    wr(32'h17, 3'd0, 32'h12FF_FFFF, "wr byte 0x17");
    rd(32'h14, 32'h12EF_CAFE, "rd half lanes");

    // Burst beats with a BUSY gap; SEQ behaves like NONSEQ.
    wr(32'h20, 3'd2, 32'h0102_0304, "burst wr0");
    beat(1'b1, HTRANS_SEQ,  1'b1, 32'h24, 3'd2, 32'h0506_0708, "burst wr1", 32'h0);
    beat(1'b1, HTRANS_BUSY, 1'b1, 32'h28, 3'd2, 32'hFFFF_FFFF, "busy", 32'h0);
    rd(32'h20, 32'h0102_0304, "burst rd0");
    beat(1'b1, HTRANS_SEQ,  1'b0, 32'h24, 3'd2, 32'h0, "burst rd1", 32'h0506_0708);

    // IDLE while selected, then NONSEQ while deselected: no access.
    beat(1'b1, HTRANS_IDLE,   1'b1, 32'h10, 3'd2, 32'hFFFF_FFFF, "idle wr", 32'h0);
    beat(1'b0, HTRANS_NONSEQ, 1'b1, 32'h10, 3'd2, 32'hFFFF_FFFF, "desel wr", 32'h0);
    idle();
    rd(32'h10, 32'h0000_AA00, "rd after idle");

`ifdef AHB_ERR_RESP_EN
    wr(32'h000, 3'd2, 32'hCAFE_F00D, "wr 0x000");
    err_xfer(1'b1, 32'h400, 3'd2, "oor wr 0x400");
    rd(32'h000, 32'hCAFE_F00D, "rd 0x000 kept");
    err_xfer(1'b1, 32'h042, 3'd2, "misaligned word");
    err_xfer(1'b1, 32'h015, 3'd1, "misaligned half");
    err_xfer(1'b1, 32'h030, 3'd3, "oversize");
    err_xfer(1'b0, 32'h800, 3'd2, "oor rd 0x800");
    rd(32'h010, 32'h0000_AA00, "rd 0x010 kept");
`else
    wr(32'h400, 3'd2, 32'h1234_5678, "wrap wr 0x400");
    rd(32'h000, 32'h1234_5678, "wrap rd 0x000");
    wr(32'h030, 3'd3, 32'hA5A5_5A5A, "oversize wr");
    rd(32'h030, 32'hA5A5_5A5A, "oversize rd");
    wr(32'h042, 3'd2, 32'h0BAD_F00D, "misaligned wr");
    rd(32'h043, 32'h0BAD_F00D, "misaligned rd");
`endif

    // Reset during a write data phase drops the write.
    wr(32'h50, 3'd2, 32'h1111_2222, "wr 0x50");
    wr(32'h50, 3'd2, 32'h3333_4444, "wr 0x50 dropped");
    bus.htrans = HTRANS_IDLE;
    bus.hwdata = wdata_pend;
    wdata_pend = 32'h0;
    #1 hresetn = 1'b1;
    @(posedge hclk); #1;
    check("mid-reset hreadyout", 64'(bus.hreadyout), 64'd1);
    check("mid-reset hrdata",    64'(bus.hrdata),    64'd0);
    @(posedge hclk); #1;
    hresetn = 1'b0;
    rd(32'h50, 32'h1111_2222, "rd 0x50 retained");
    idle();
    idle();

    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d", passes, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/modport_slave.md
MODPORT_SLAVE -- requirements
Module: modport_slave

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: hclk samples on rising edge; hresetn asserts when high, despite the suffix.
REQ-002 Parameters SHALL be:
- ADDR_WIDTH, default 32: haddr width.
- DATA_WIDTH, default 32: hwdata/hrdata width.
- MEM_DEPTH, default 256: number of DATA_WIDTH words.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- hclk  in  1  clock.
- hresetn  in  1  async reset, active-high.
- hsel  in  1  slave select.
- haddr  in  ADDR_WIDTH  byte address.
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwrite  in  1  1 = write.
- hsize  in  3  0 = byte, 1 = half, 2 = word.
- hburst  in  3  burst type, informational only.
- hprot  in  4  ignored.
- hready  in  1  bus ready.
- hwdata  in  DATA_WIDTH  write data.
- hrdata  out  DATA_WIDTH  read data.
- hreadyout  out  1  slave ready.
- hresp  out  2  OKAY=0, ERROR=1.

Function
REQ-004 A transfer SHALL be accepted in its address phase only when hsel=1, hready=1 and htrans is NONSEQ or SEQ; the accepted address phase registers haddr, hwrite and hsize.
REQ-005 IDLE or BUSY, or hsel=0, SHALL cause no access and give an OKAY, zero-wait response.
REQ-006 Writes:
- hwdata SHALL be taken in the data phase, the cycle after acceptance.
- Memory SHALL update at the data-phase end edge, only on byte lanes selected by the registered hsize and haddr[1:0] (little-endian).
REQ-007 Reads:
- hrdata SHALL be combinational from memory at the registered word index during the data phase, full word on all lanes.
- hrdata SHALL be 0 outside a read data phase.
REQ-008 Read-after-write to the same address in back-to-back transfers SHALL return the newly written data; no bypass is needed, because the write commits at the same edge the read address is registered.
REQ-009 The word index SHALL be haddr[log2(MEM_DEPTH)+1:2].
REQ-010 Successful transfers SHALL be zero-wait: hreadyout=1 and hresp=OKAY.
REQ-011 hburst SHALL NOT affect behaviour; each beat of a burst is an independent transfer, and SEQ is treated as NONSEQ.
REQ-012 hsize>2 SHALL be treated as word when AHB_ERR_RESP_EN is undefined.

Reset
REQ-013 While hresetn=1:
- hreadyout=1, hresp=OKAY, hrdata=0.
- Pipeline registers are cleared.
- Memory contents are retained, not cleared.
REQ-014 Reset asserted mid-transfer SHALL drop any pending data-phase write; the first address phase after release is accepted normally.

Configuration
REQ-015 With AHB_ERR_RESP_EN defined, the following SHALL produce the two-cycle ERROR response:
- Out-of-range address: haddr >= MEM_DEPTH*4.
- Misaligned address: half with haddr[0]=1, or word with haddr[1:0]!=0.
- hsize>2.
REQ-016 The two-cycle ERROR response SHALL be:
- Cycle 1: hreadyout=0, hresp=ERROR.
- Cycle 2: hreadyout=1, hresp=ERROR.
- Memory is not written and hrdata=0.
- A transfer presented during cycle 1 is not accepted, since hready=0.
REQ-017 Without AHB_ERR_RESP_EN, the block SHALL NOT produce ERROR:
- Addresses wrap modulo MEM_DEPTH words.
- Misalignment low bits are ignored; lanes are taken from the aligned size.
- hreadyout stays 1.

Structure
REQ-018 Package ahb_pkg SHALL hold:
- htrans_e, hresp_e, hsize_e and hburst_e encodings.
- Default DATA_WIDTH, ADDR_WIDTH and MEM_DEPTH constants.
REQ-019 One sub-module, ahb_slave_mem, SHALL implement the byte-lane-enable memory: one write port, one combinational read port.
REQ-020 The AHB pipeline and response FSM SHALL stay in modport_slave, with FSM states IDLE, ERR1 and ERR2 (ERR states only under the macro).

Verification
REQ-021 Word write then read, back to back: NONSEQ write haddr=0x10 with hwdata=0xDEADBEEF, then NONSEQ read of 0x10 -> hrdata=0xDEADBEEF with hresp=OKAY and no wait.
REQ-022 Byte write: write byte 0xAA to haddr=0x11 over a word at 0x10 holding 0x00000000 -> word reads 0x0000AA00.
REQ-023 Idle and deselect: IDLE with hsel=1, then NONSEQ with hsel=0 -> memory unchanged, hreadyout=1, hresp=OKAY.
REQ-024 Out-of-range access with macro: write to haddr=0x400 with MEM_DEPTH=256 -> hreadyout 0 then 1, hresp=ERROR for 2 cycles, and 0x000 unchanged.
REQ-025 Out-of-range access without macro: write 0x12345678 to haddr=0x400 -> OKAY, and haddr=0x000 reads 0x12345678.
REQ-026 Reset mid-transfer: assert hresetn during a write data phase -> write dropped, outputs at reset values, and memory retains prior data.
